// File: rtl/chunk_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chunk_add_pkg
// Purpose  : Shared definitions for the chunked sequential adder: FSM state
//            encoding, default geometry and the chunk counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package chunk_add_pkg;

  // FSM state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default geometry: 4 chunks of 4 bits -> 16-bit operands
  localparam int DEF_WIDETH = 4;
  localparam int DEF_CHUNKS = 4;

  // Width of the chunk counter; never narrower than one bit so that a
  // single-chunk configuration still has a legal vector.
  function automatic int cnt_w(input int chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage : chunk_add_pkg
`default_nettype wire

// File: rtl/full_add.sv
`default_nettype none
// ============================================================================
// Module   : full_add
// Purpose  : Combinational WIDETH-bit ripple adder with carry in/out.
// Ports    : a, b   - addends (WIDETH bits)
//            cin    - carry in
//            sum    - (a + b + cin) mod 2^WIDETH
//            cout   - carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
module full_add #(
  parameter int WIDETH = 4
) (
  input  logic [WIDETH-1:0] a,
  input  logic [WIDETH-1:0] b,
  input  logic              cin,
  output logic [WIDETH-1:0] sum,
  output logic              cout
);

  logic [WIDETH:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {{WIDETH{1'b0}}, cin};
  assign sum     = w_total[WIDETH-1:0];
  assign cout    = w_total[WIDETH];

endmodule : full_add
`default_nettype wire

// File: rtl/chunk_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : chunk_add_seq
// Purpose  : Sequential multi-word adder. Adds two WIDETH*CHUNKS-bit operands
//            one WIDETH-bit chunk per cycle, LSB chunk first, through a single
//            full_add stage. Operands in and result out use valid/ready.
// Ports    : clk, rst          - clock, async active-high reset
//            in_valid/in_ready - operand handshake (in_ready = IDLE)
//            in_a, in_b, in_cin- operands and carry into chunk 0
//            out_valid/out_ready - result handshake (out_valid = DONE)
//            out_sum, out_cout - result and carry out of the MSB chunk
//            busy              - high while chunks are being added
// Revision : 1.0 - initial release
// ============================================================================
module chunk_add_seq
  import chunk_add_pkg::*;
#(
  parameter int WIDETH = DEF_WIDETH,
  parameter int CHUNKS = DEF_CHUNKS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDETH*CHUNKS-1:0] in_a,
  input  logic [WIDETH*CHUNKS-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDETH*CHUNKS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int          N      = WIDETH * CHUNKS;
  localparam int          CW     = cnt_w(CHUNKS);
  localparam logic [CW-1:0] C_LAST = CW'(CHUNKS - 1);

  logic [1:0]        r_state;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  logic [N-1:0]      r_sum;
  logic              r_carry;
  logic [CW-1:0]     r_cnt;

  logic [WIDETH-1:0] w_sum;
  logic              w_cout;
  logic [N-1:0]      w_sum_next;

  // The only arithmetic per cycle: one WIDETH-bit ripple on the low chunk.
  full_add #(
    .WIDETH (WIDETH)
  ) u_full_add (
    .a    (r_a[WIDETH-1:0]),
    .b    (r_b[WIDETH-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // New chunk enters at the top of the sum register; after CHUNKS shifts
  // chunk 0 has migrated down to the LSB position.
  generate
    if (CHUNKS == 1) begin : g_sum_single
      assign w_sum_next = w_sum;
    end else begin : g_sum_shift
      assign w_sum_next = {w_sum, r_sum[N-1:WIDETH]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_a     <= r_a >> WIDETH;
          r_b     <= r_b >> WIDETH;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags decode registered state only.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_CALC);
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;

endmodule : chunk_add_seq
`default_nettype wire

// File: tb/tb_chunk_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunk_add_seq
// Purpose  : Self-checking bench for chunk_add_seq (WIDETH=4, CHUNKS=4).
//            Directed corner cases plus random operands against a plain
//            arithmetic reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunk_add_seq;

  localparam int WIDETH = 4;
  localparam int CHUNKS = 4;
  localparam int N      = WIDETH * CHUNKS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int n_chk;
  int n_err;

  chunk_add_seq #(
    .WIDETH (WIDETH),
    .CHUNKS (CHUNKS)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction. bp = cycles of out_ready low in DONE;
  // poke = drive a stray in_valid during that window.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input int bp, input bit poke);
    logic [N:0]   full;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
    full     = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    exp_sum  = full[N-1:0];
    exp_cout = full[N];

    @(negedge clk);
    check_val("idle_in_ready", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);                    // accept edge E0
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;                     // operands must already be captured
    in_b     = ~b;
    in_cin   = ~cin;
    check_val("calc_busy", 32'(busy), 32'd1);
    check_val("calc_in_ready", 32'(in_ready), 32'd0);
    // out_valid must rise exactly CHUNKS edges after accept
    for (int k = 1; k <= CHUNKS; k++) begin
      check_val("early_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check_val("out_valid", 32'(out_valid), 32'd1);
    check_val("out_sum", 32'(out_sum), 32'(exp_sum));
    check_val("out_cout", 32'(out_cout), 32'(exp_cout));

    for (int c = 0; c < bp; c++) begin
      if (poke && c == 1) begin
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_busy", 32'(busy), 32'd0);
      check_val("bp_sum_hold", 32'(out_sum), 32'(exp_sum));
      check_val("bp_cout_hold", 32'(out_cout), 32'(exp_cout));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);                    // result handshake
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_out_valid", 32'(out_valid), 32'd0);
    check_val("post_in_ready", 32'(in_ready), 32'd1);
    check_val("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_sum", 32'(out_sum), 32'd0);
    check_val("rst_out_cout", 32'(out_cout), 32'd0);
    rst = 1'b0;

    // Directed corners
    do_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    do_op(16'h000F, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    // Backpressure with a stray in_valid pulse
    do_op(16'h8421, 16'h7BDE, 1'b1, 5, 1'b1);

    // Reset mid-operation after two CALC edges
    @(negedge clk);
    in_a     = 16'hABCD;
    in_b     = 16'h1111;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst_out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

    // Random operands with random backpressure
    for (int i = 0; i < 25; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_chunk_add_seq
`default_nettype wire
